// File: rtl/fp32_pkg.sv
// -----------------------------------------------------------------------------
// fp32_pkg
// Shared IEEE-754 single-precision definitions: field widths, exponent bias,
// the canonical quiet NaN, an operand classification enum and a classifier.
// Denormals classify as FP_ZERO (flush-to-zero datapath).
// -----------------------------------------------------------------------------
package fp32_pkg;

   localparam int          EXP_W   = 8;
   localparam int          FRAC_W  = 23;
   localparam int          BIAS    = 127;
   localparam int          EXP_MAX = 255;
   localparam logic [31:0] QNAN    = 32'h7FC0_0000;

   typedef enum logic [1:0] {
      FP_ZERO,
      FP_NORM,
      FP_INF,
      FP_NAN
   } fp_class_e;

   function automatic fp_class_e fp_classify(input logic [31:0] x);
      logic [EXP_W-1:0]  e;
      logic [FRAC_W-1:0] f;
      e = x[30:23];
      f = x[22:0];
      if (e == '0)
         return FP_ZERO;
      else if (e == EXP_W'(EXP_MAX))
         return (f == '0) ? FP_INF : FP_NAN;
      else
         return FP_NORM;
   endfunction

endpackage

// File: rtl/fp32_round_norm.sv
// -----------------------------------------------------------------------------
// fp32_round_norm
// Combinational normalise + round-to-nearest-even for a 48-bit product of two
// 24-bit significands (hidden 1 included), so the product lies in [1, 4).
//   prod_i  : 48-bit significand product
//   exp_i   : signed biased exponent before normalisation
//   frac_o  : 23-bit rounded fraction (hidden 1 dropped)
//   exp_o   : signed biased exponent after normalisation and rounding carry
// -----------------------------------------------------------------------------
module fp32_round_norm
   import fp32_pkg::*;
(
   input  logic        [47:0]       prod_i,
   input  logic signed [9:0]        exp_i,
   output logic        [FRAC_W-1:0] frac_o,
   output logic signed [9:0]        exp_o
);

   logic [FRAC_W-1:0] frac_t;
   logic [FRAC_W:0]   frac_rnd;
   logic signed [9:0] exp_t;
   logic              guard;
   logic              sticky;
   logic              round_up;

   // NOTE: every signal assigned in this block gets a default first, so no
   // path can leave one unassigned and infer a latch.
   always_comb begin
      frac_t = prod_i[45:23];
      guard  = prod_i[22];
      sticky = |prod_i[21:0];
      exp_t  = exp_i;
      // Product in [2, 4): shift one further right and bump the exponent.
      if (prod_i[47]) begin
         frac_t = prod_i[46:24];
         guard  = prod_i[23];
         sticky = |prod_i[22:0];
         exp_t  = exp_i + 10'sd1;
      end

      round_up = guard & (sticky | frac_t[0]);
      frac_rnd = {1'b0, frac_t} + {{FRAC_W{1'b0}}, round_up};

      frac_o = frac_rnd[FRAC_W-1:0];
      exp_o  = exp_t;
      // All-ones fraction rounded up: significand becomes 2.0 -> 1.0 x 2^1.
      if (frac_rnd[FRAC_W]) begin
         frac_o = '0;
         exp_o  = exp_t + 10'sd1;
      end
   end

endmodule

// File: rtl/fp32_pipe_multiplier.sv
// -----------------------------------------------------------------------------
// fp32_pipe_multiplier
// Three-stage pipelined IEEE-754 single-precision multiplier with valid/ready
// on both sides and a sideband tag carried alongside each product.
//   Stage 1: unpack, classify, exponent sum, 24x24 significand product
//   Stage 2: normalise and round (fp32_round_norm)
//   Stage 3: special-case resolution and packing into the output register
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          operand handshake; in_a, in_b, in_tag
//   out_valid/out_ready        result handshake; result, out_tag
//   overflow/underflow/exception  per-result flags, valid with out_valid
// All stages advance together whenever the output slot is free or consumed.
// -----------------------------------------------------------------------------
module fp32_pipe_multiplier
   import fp32_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_a,
   input  logic [XLEN-1:0]  in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  result,
   output logic [TAG_W-1:0] out_tag,
   output logic             overflow,
   output logic             underflow,
   output logic             exception
);

   localparam logic signed [9:0] BIAS_S    = 10'(BIAS);
   localparam logic signed [9:0] EXP_MAX_S = 10'(EXP_MAX);

   logic en;

   // ---------------- stage 1: unpack ----------------
   fp_class_e         cls_a, cls_b;
   logic signed [9:0] exp_sum;
   logic [47:0]       prod;

   assign cls_a   = fp_classify(in_a);
   assign cls_b   = fp_classify(in_b);
   assign exp_sum = $signed({2'b00, in_a[30:23]}) + $signed({2'b00, in_b[30:23]}) - BIAS_S;
   assign prod    = 48'({1'b1, in_a[FRAC_W-1:0]}) * 48'({1'b1, in_b[FRAC_W-1:0]});

   logic              s1_valid_q;
   logic [TAG_W-1:0]  s1_tag_q;
   logic              s1_sign_q;
   fp_class_e         s1_cls_a_q, s1_cls_b_q;
   logic signed [9:0] s1_exp_q;
   logic [47:0]       s1_prod_q;

   // ---------------- stage 2: normalise / round ----------------
   logic [FRAC_W-1:0] rn_frac;
   logic signed [9:0] rn_exp;

   fp32_round_norm u_round_norm (
      .prod_i (s1_prod_q),
      .exp_i  (s1_exp_q),
      .frac_o (rn_frac),
      .exp_o  (rn_exp)
   );

   logic              s2_valid_q;
   logic [TAG_W-1:0]  s2_tag_q;
   logic              s2_sign_q;
   fp_class_e         s2_cls_a_q, s2_cls_b_q;
   logic signed [9:0] s2_exp_q;
   logic [FRAC_W-1:0] s2_frac_q;

   // ---------------- stage 3: special cases and pack ----------------
   logic [XLEN-1:0]  result_d;
   logic             overflow_d, underflow_d, exception_d;
   logic             any_nan, any_inf, any_zero;

   logic             out_valid_q;
   logic [XLEN-1:0]  result_q;
   logic [TAG_W-1:0] out_tag_q;
   logic             overflow_q, underflow_q, exception_q;

   assign any_nan  = (s2_cls_a_q == FP_NAN)  || (s2_cls_b_q == FP_NAN);
   assign any_inf  = (s2_cls_a_q == FP_INF)  || (s2_cls_b_q == FP_INF);
   assign any_zero = (s2_cls_a_q == FP_ZERO) || (s2_cls_b_q == FP_ZERO);

   always_comb begin
      result_d    = {s2_sign_q, s2_exp_q[EXP_W-1:0], s2_frac_q};
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      exception_d = 1'b0;
      if (any_nan || (any_inf && any_zero)) begin
         result_d    = QNAN;
         exception_d = 1'b1;
      end else if (any_inf) begin
         result_d    = {s2_sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
         exception_d = 1'b1;
      end else if (any_zero) begin
         result_d    = {s2_sign_q, {(XLEN-1){1'b0}}};
      end else if (s2_exp_q >= EXP_MAX_S) begin
         result_d    = {s2_sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
         overflow_d  = 1'b1;
      end else if (s2_exp_q <= 10'sd0) begin
         result_d    = {s2_sign_q, {(XLEN-1){1'b0}}};
         underflow_d = 1'b1;
      end
   end

   // ---------------- pipeline control ----------------
   assign en       = !out_valid_q || out_ready;
   assign in_ready = en;

   // NOTE: sequential state is written with non-blocking assignments so every
   // stage samples the previous stage's value from before this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         out_tag_q   <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         exception_q <= 1'b0;
      end else if (en) begin
         s1_valid_q  <= in_valid;
         s2_valid_q  <= s1_valid_q;
         out_valid_q <= s2_valid_q;
         // Output data only loads with a real result, so bubbles leave the
         // last result (or the reset zeros) on the bus.
         if (s2_valid_q) begin
            result_q    <= result_d;
            out_tag_q   <= s2_tag_q;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            exception_q <= exception_d;
         end
      end
   end

   // NOTE: internal datapath registers carry no reset; their contents are
   // ignored until the matching valid bit, which is reset, marks them live.
   always_ff @(posedge clk) begin
      if (en) begin
         s1_tag_q   <= in_tag;
         s1_sign_q  <= in_a[XLEN-1] ^ in_b[XLEN-1];
         s1_cls_a_q <= cls_a;
         s1_cls_b_q <= cls_b;
         s1_exp_q   <= exp_sum;
         s1_prod_q  <= prod;

         s2_tag_q   <= s1_tag_q;
         s2_sign_q  <= s1_sign_q;
         s2_cls_a_q <= s1_cls_a_q;
         s2_cls_b_q <= s1_cls_b_q;
         s2_exp_q   <= rn_exp;
         s2_frac_q  <= rn_frac;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign out_tag   = out_tag_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
   assign exception = exception_q;

endmodule
